trax_turn_controller: RTL

- Turn sequencer between the TRAX game engine and the serial move tranceiver.
- Latches the colour reported by the tranceiver, then alternates turns:
  - our turn: accepts the engine's 22-bit move and triggers transmission;
  - opponent's turn: waits for a received move and hands it to the engine.
- Enforces an opponent response timeout and a total-move limit, and flags protocol errors.

---
 rtl/trax_turn_controller.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/trax_turn_controller.sv
// ---------------------------------------------------------------------------
// trax_turn_controller
//   Turn sequencer between the TRAX game engine and the serial move
//   tranceiver. On game_start it takes the colour from the tranceiver and then
//   alternates turns: on our turn it accepts the engine's move and fires a
//   one-cycle transmit trigger; on the opponent's turn it waits for a
//   received move and hands it to the engine. It enforces an opponent
//   response timeout and a total-move limit, and flags stray receives.
//
// Ports
//   clock, reset        rising-edge clock, asynchronous active-high reset
//   game_start          start pulse, honoured only in IDLE
//   eng_move/valid      move offered by the engine
//   eng_ready           high only while waiting for the engine's move
//   opp_move/valid      received opponent move offered to the engine
//   opp_ready           engine consumes opp_move
//   trx_move_in         move presented to the tranceiver
//   trx_start_transmit  one-cycle transmit trigger
//   trx_tx_done         tranceiver finished sending
//   trx_move_out        decoded received move
//   trx_end_receive     one-cycle pulse: trx_move_out valid
//   trx_color           1 = we move first
//   my_turn             high while our move is being taken or sent
//   move_count          moves completed (sent plus received)
//   timeout             sticky: opponent failed to answer in time
//   proto_err           sticky: trx_end_receive arrived outside WAIT_RX
//   game_over           high once the game has ended
// ---------------------------------------------------------------------------
module trax_turn_controller #(
  parameter int MOVE_W         = 22,
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int MAX_MOVES      = 255
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              game_start,
  input  logic [MOVE_W-1:0] eng_move,
  input  logic              eng_valid,
  output logic              eng_ready,
  output logic [MOVE_W-1:0] opp_move,
  output logic              opp_valid,
  input  logic              opp_ready,
  output logic [MOVE_W-1:0] trx_move_in,
  output logic              trx_start_transmit,
  input  logic              trx_tx_done,
  input  logic [MOVE_W-1:0] trx_move_out,
  input  logic              trx_end_receive,
  input  logic              trx_color,
  output logic              my_turn,
  output logic [7:0]        move_count,
  output logic              timeout,
  output logic              proto_err,
  output logic              game_over
);

  localparam int TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0] MOVE_LIMIT = 8'(MAX_MOVES);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_ENG,
    SEND,
    WAIT_TX,
    WAIT_RX,
    DELIVER,
    DONE
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [TMR_W-1:0] tmr;
  logic [7:0]       count_inc;

  // Datapath strobes produced by the next-state logic
  logic cap_eng;
  logic cap_rx;
  logic inc_count;
  logic set_timeout;
  logic set_proto;
  logic clr_tmr;

  assign count_inc = move_count + 8'd1;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next         = state;
    cap_eng            = 1'b0;
    cap_rx             = 1'b0;
    inc_count          = 1'b0;
    set_timeout        = 1'b0;
    clr_tmr            = 1'b0;
    eng_ready          = 1'b0;
    opp_valid          = 1'b0;
    trx_start_transmit = 1'b0;
    my_turn            = 1'b0;
    game_over          = 1'b0;

    case (state)
      IDLE: begin
        if (game_start) begin
          if (trx_color) begin
            state_next = WAIT_ENG;
          end else begin
            state_next = WAIT_RX;
            clr_tmr    = 1'b1;
          end
        end
      end
      WAIT_ENG: begin
        eng_ready = 1'b1;
        my_turn   = 1'b1;
        if (eng_valid) begin
          cap_eng    = 1'b1;
          state_next = SEND;
        end
      end
      SEND: begin
        trx_start_transmit = 1'b1;
        my_turn            = 1'b1;
        state_next         = WAIT_TX;
      end
      WAIT_TX: begin
        my_turn = 1'b1;
        if (trx_tx_done) begin
          inc_count = 1'b1;
          if (count_inc == MOVE_LIMIT) begin
            state_next = DONE;
          end else begin
            state_next = WAIT_RX;
            clr_tmr    = 1'b1;
          end
        end
      end
      WAIT_RX: begin
        // A receive landing on the expiry cycle takes priority over timeout
        if (trx_end_receive) begin
          cap_rx     = 1'b1;
          state_next = DELIVER;
        end else if (tmr == TMR_LAST) begin
          set_timeout = 1'b1;
          state_next  = DONE;
        end
      end
      DELIVER: begin
        opp_valid = 1'b1;
        if (opp_ready) begin
          inc_count  = 1'b1;
          state_next = (count_inc == MOVE_LIMIT) ? DONE : WAIT_ENG;
        end
      end
      DONE: begin
        game_over = 1'b1;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // A stray receive is flagged and dropped; it never moves the FSM
  assign set_proto = trx_end_receive && (state != WAIT_RX);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      trx_move_in <= '0;
      opp_move    <= '0;
      move_count  <= '0;
      timeout     <= 1'b0;
      proto_err   <= 1'b0;
      tmr         <= '0;
    end else begin
      if (cap_eng) begin
        trx_move_in <= eng_move;
      end
      if (cap_rx) begin
        opp_move <= trx_move_out;
      end
      if (inc_count) begin
        move_count <= count_inc;
      end
      if (set_timeout) begin
        timeout <= 1'b1;
      end
      if (set_proto) begin
        proto_err <= 1'b1;
      end
      if (clr_tmr) begin
        tmr <= '0;
      end else if (state == WAIT_RX) begin
        tmr <= tmr + TMR_W'(1);
      end
    end
  end

endmodule
